scandblr_cfg_ctrl: RTL and testbench

Owns the external SRAM configuration byte that holds the video output settings (SCANDBLR_CTRL layout) and supplies the live value to the scandoubler. After reset it waits a boot delay, then reads the byte from the SRAM at a fixed magic address. From then on it applies keyboard hotkey toggles and writes the updated byte back with a timed write cycle. Sits between the keyboard, the vga_scandoubler enables, and the SRAM pins.

---
 rtl/scandblr_cfg_ctrl.sv | 125 ++++++++++++
 tb/tb_scandblr_cfg_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scandblr_cfg_ctrl.sv
// Scandoubler settings byte owner: boot-reads the byte from SRAM, applies hotkey toggles, writes it back.
// Latency: first IDLE BOOT_DELAY+RD_WAIT clocks after reset release; toggle in IDLE -> byte updated next clock.
// Backpressure: none; toggles latch into sticky pending flags and are served after the current read/write ends.
module scandblr_cfg_ctrl #(
  parameter logic [20:0] CFG_ADDR   = 21'h008FD5,
  parameter int unsigned BOOT_DELAY = 8,
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned WR_WAIT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        toggle_sd,
  input  logic        toggle_scan,
  input  logic [7:0]  sram_data_in,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_data_out,
  output logic        sram_data_oe,
  output logic        sram_we_n,
  output logic [7:0]  scandblr_reg,
  output logic        cfg_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_BOOT, S_RD, S_IDLE, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD
  } state_e;

  // Terminal counts: the counter restarts at 0 on every state entry.
  localparam logic [7:0] BOOT_LAST = 8'(BOOT_DELAY - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_WAIT - 1);
  localparam logic [7:0] WR_LAST   = 8'(WR_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] reg_q, reg_d;
  logic       valid_q, valid_d;
  logic       pend_sd_q, pend_sd_d;
  logic       pend_scan_q, pend_scan_d;
  logic       we_n_q, we_n_d;
  logic       oe_q, oe_d;
  logic       consume;
  logic       rd_done;

  // A pending toggle is served only from IDLE; both flags are consumed together.
  assign consume = (state_q == S_IDLE) && (pend_sd_q || pend_scan_q);
  assign rd_done = (state_q == S_RD) && (cnt_q == RD_LAST);

  // State, counter, settings byte and registered SRAM strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      cnt_q       <= 8'd0;
      reg_q       <= 8'h00;
      valid_q     <= 1'b0;
      pend_sd_q   <= 1'b0;
      pend_scan_q <= 1'b0;
      we_n_q      <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_q       <= reg_d;
      valid_q     <= valid_d;
      pend_sd_q   <= pend_sd_d;
      pend_scan_q <= pend_scan_d;
      we_n_q      <= we_n_d;
      oe_q        <= oe_d;
    end
  end

  // Next state and dwell counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    unique case (state_q)
      S_BOOT: begin
        if (cnt_q == BOOT_LAST) state_d = S_RD;
        else                    cnt_d   = cnt_q + 8'd1;
      end
      S_RD: begin
        if (rd_done) state_d = S_IDLE;
        else         cnt_d   = cnt_q + 8'd1;
      end
      S_IDLE: begin
        if (consume) state_d = S_WR_SETUP;
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        if (cnt_q == WR_LAST) state_d = S_WR_HOLD;
        else                  cnt_d   = cnt_q + 8'd1;
      end
      S_WR_HOLD: state_d = S_IDLE;
      default:   state_d = S_BOOT;
    endcase
  end

  // Settings byte and pending flags; a new pulse wins over a same-cycle clear.
  always_comb begin
    reg_d       = reg_q;
    valid_d     = valid_q;
    pend_sd_d   = (pend_sd_q && !consume) || toggle_sd;
    pend_scan_d = (pend_scan_q && !consume) || toggle_scan;
    if (rd_done) begin
      reg_d   = sram_data_in;
      valid_d = 1'b1;
    end else if (consume) begin
      reg_d = {reg_q[7:2], reg_q[1] ^ pend_scan_q, reg_q[0] ^ pend_sd_q};
    end
  end

  // Strobes decoded from the next state so the pins come straight from flops.
  always_comb begin
    oe_d   = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
    we_n_d = (state_d != S_WR_PULSE);
  end

  assign sram_addr     = CFG_ADDR;
  assign sram_data_out = reg_q;
  assign sram_data_oe  = oe_q;
  assign sram_we_n     = we_n_q;
  assign scandblr_reg  = reg_q;
  assign cfg_valid     = valid_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_scandblr_cfg_ctrl.sv
// Bench for scandblr_cfg_ctrl: timeline model of boot read and write cycles, directed and random toggles.
module tb_scandblr_cfg_ctrl;
  localparam int BD = 8;
  localparam int RW = 2;
  localparam int WW = 2;
  localparam int BR = BD + RW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        toggle_sd = 1'b0;
  logic        toggle_scan = 1'b0;
  logic [7:0]  sram_data_in = 8'h03;
  logic [20:0] sram_addr;
  logic [7:0]  sram_data_out;
  logic        sram_data_oe;
  logic        sram_we_n;
  logic [7:0]  scandblr_reg;
  logic        cfg_valid;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  scandblr_cfg_ctrl #(.CFG_ADDR(21'h008FD5), .BOOT_DELAY(BD), .RD_WAIT(RW), .WR_WAIT(WW)) dut (
    .clk(clk), .rst_n(rst_n), .toggle_sd(toggle_sd), .toggle_scan(toggle_scan),
    .sram_data_in(sram_data_in), .sram_addr(sram_addr), .sram_data_out(sram_data_out),
    .sram_data_oe(sram_data_oe), .sram_we_n(sram_we_n), .scandblr_reg(scandblr_reg),
    .cfg_valid(cfg_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset release, and the edge at which the latest write began.
  int         n = 0;
  int         wr_start = -100;
  logic [7:0] mreg = 8'h00;
  logic       mvalid = 1'b0;
  logic       psd = 1'b0;
  logic       pscan = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; wr_start = -100; mreg = 8'h00; mvalid = 1'b0; psd = 1'b0; pscan = 1'b0;
    end else begin
      bit idle_prev, clr;
      idle_prev = (n >= BR) && (n >= wr_start + 2 + WW);
      n = n + 1;
      clr = idle_prev && (psd || pscan);
      if (clr) begin
        mreg[0] = mreg[0] ^ psd;
        mreg[1] = mreg[1] ^ pscan;
        wr_start = n;
      end
      if (n == BR) begin
        mreg = sram_data_in;
        mvalid = 1'b1;
      end
      psd   = (psd && !clr) || toggle_sd;
      pscan = (pscan && !clr) || toggle_scan;
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    logic e_busy, e_oe, e_we_n;
    e_busy = !((n >= BR) && (n >= wr_start + 2 + WW));
    e_oe   = (n >= wr_start) && (n < wr_start + 2 + WW);
    e_we_n = !((n >= wr_start + 1) && (n <= wr_start + WW));
    chk("busy",  {31'd0, busy},         {31'd0, e_busy});
    chk("oe",    {31'd0, sram_data_oe}, {31'd0, e_oe});
    chk("we_n",  {31'd0, sram_we_n},    {31'd0, e_we_n});
    chk("valid", {31'd0, cfg_valid},    {31'd0, mvalid});
    chk("reg",   {24'd0, scandblr_reg}, {24'd0, mreg});
    chk("wdata", {24'd0, sram_data_out},{24'd0, mreg});
    chk("addr",  {11'd0, sram_addr},    32'h0000_8FD5);
  end

  always @(negedge sram_we_n) wr_cnt++;

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] din);
    step(1);
    rst_n = 1'b0;
    sram_data_in = din;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input bit sd, input bit sc);
    toggle_sd = sd; toggle_scan = sc;
    step(1);
    toggle_sd = 1'b0; toggle_scan = 1'b0;
  endtask

  task automatic wait_we_low(input string name);
    int k = 0;
    while (sram_we_n !== 1'b0 && k < 50) begin
      step(1);
      k++;
    end
    if (sram_we_n !== 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: we_n never went low within 50 cycles", name);
    end
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'd0, sram_data_oe}, 32'd0);
    chk("rst_reg", {24'd0, scandblr_reg}, 32'h00);

    // Boot read of 03: valid exactly BR edges after release
    sram_data_in = 8'h03;
    rst_n = 1'b1;
    step(BR - 1);
    chk("boot_valid_early", {31'd0, cfg_valid}, 32'd0);
    step(1);
    chk("boot_valid", {31'd0, cfg_valid}, 32'd1);
    chk("boot_reg", {24'd0, scandblr_reg}, 32'h03);
    sram_data_in = 8'hA5;

    // Single toggle: 03 -> 02, oe next, we_n low for WW clocks
    step(2);
    wr_cnt = 0;
    pulse(1'b1, 1'b0);
    step(1);
    chk("tog_reg", {24'd0, scandblr_reg}, 32'h02);
    chk("tog_oe", {31'd0, sram_data_oe}, 32'd1);
    chk("tog_we_setup", {31'd0, sram_we_n}, 32'd1);
    step(1);
    chk("tog_we_low", {31'd0, sram_we_n}, 32'd0);
    chk("tog_wdata", {24'd0, sram_data_out}, 32'h02);
    step(WW + 2);
    chk("tog_wr_cnt", wr_cnt, 32'd1);
    chk("tog_idle", {31'd0, busy}, 32'd0);

    // Early toggle during BOOT with SRAM byte 81
    do_reset(8'h81);
    step(2);
    pulse(1'b0, 1'b1);
    wr_cnt = 0;
    step(BR - 3);
    chk("early_read", {24'd0, scandblr_reg}, 32'h81);
    step(1);
    chk("early_tog", {24'd0, scandblr_reg}, 32'h83);
    step(WW + 3);
    chk("early_wr_cnt", wr_cnt, 32'd1);

    // Simultaneous and repeated toggles collapse into one write of 03
    do_reset(8'h00);
    step(1);
    pulse(1'b1, 1'b1);
    step(1);
    pulse(1'b1, 1'b0);
    wr_cnt = 0;
    step(BR + WW + 6);
    chk("simul_reg", {24'd0, scandblr_reg}, 32'h03);
    chk("simul_wr_cnt", wr_cnt, 32'd1);

    // Toggle during write: two complete writes, 03 -> 02 -> 00
    wr_cnt = 0;
    pulse(1'b1, 1'b0);
    wait_we_low("during_wr");
    pulse(1'b0, 1'b1);
    chk("during_first_data", {24'd0, sram_data_out}, 32'h02);
    step(2 * (WW + 3) + 2);
    chk("during_wr_cnt", wr_cnt, 32'd2);
    chk("during_reg", {24'd0, scandblr_reg}, 32'h00);

    // Reset mid-write takes effect without a clock edge
    pulse(1'b0, 1'b1);
    wait_we_low("mid_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("mid_rst_oe", {31'd0, sram_data_oe}, 32'd0);
    chk("mid_rst_reg", {24'd0, scandblr_reg}, 32'h00);
    chk("mid_rst_valid", {31'd0, cfg_valid}, 32'd0);
    sram_data_in = 8'h55;
    step(2);
    rst_n = 1'b1;
    step(BR);
    chk("reboot_reg", {24'd0, scandblr_reg}, 32'h55);

    // Random toggles, data and occasional resets against the model
    for (int i = 0; i < 3000; i++) begin
      toggle_sd    = ($urandom_range(0, 7) == 0);
      toggle_scan  = ($urandom_range(0, 7) == 0);
      sram_data_in = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end
    toggle_sd = 1'b0;
    toggle_scan = 1'b0;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
